// File: rtl/register_file_if.sv
// Decode-stage register file bus: two read ports with use qualifiers,
// the issue (destination reservation) port, the writeback port, and the
// scoreboard status returned to decode.
interface register_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] readAddr1;
    logic [ADDR_W-1:0] readAddr2;
    logic              readUse1;
    logic              readUse2;
    logic [WIDTH-1:0]  readData1;
    logic [WIDTH-1:0]  readData2;
    logic              busy1;
    logic              busy2;
    logic              stall;
    logic              issueEn;
    logic [ADDR_W-1:0] issueAddr;
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [WIDTH-1:0]  writeData;
    logic [ADDR_W:0]   pendingCount;

    // Decoder / pipeline side: drives addresses, issue and writeback
    modport master (
        output readAddr1, readAddr2, readUse1, readUse2,
        output issueEn, issueAddr,
        output writeEn, writeAddr, writeData,
        input  readData1, readData2, busy1, busy2, stall, pendingCount
    );

    // Register file side
    modport slave (
        input  readAddr1, readAddr2, readUse1, readUse2,
        input  issueEn, issueAddr,
        input  writeEn, writeAddr, writeData,
        output readData1, readData2, busy1, busy2, stall, pendingCount
    );
endinterface

// File: rtl/register_file.sv
// Two-read, one-write register file with a per-register pending-write
// scoreboard. Register 0 reads as zero and is never pending.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the
// read ports (data and busy); without it, reads come only from storage.
module register_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic            clock,
    input logic            rst,
    register_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pendingNext;
    logic [ADDR_W:0]  countNext;
    logic [ADDR_W:0]  pendingCount;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             b1;
    logic             b2;

    // Storage array: cleared on reset, writes to register 0 are dropped
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.writeEn && bus.writeAddr != '0) begin
            mem[bus.writeAddr] <= bus.writeData;
        end
    end

    // Next pending vector: writeback clears, a same-edge issue wins over it
    always_comb begin
        pendingNext = pending;
        if (bus.writeEn) begin
            pendingNext[bus.writeAddr] = 1'b0;
        end
        if (bus.issueEn) begin
            pendingNext[bus.issueAddr] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    // Population count of the next vector so the registered count is never stale
    always_comb begin
        countNext = '0;
        for (int i = 0; i < DEPTH; i++) begin
            countNext = countNext + {{ADDR_W{1'b0}}, pendingNext[i]};
        end
    end

    // Scoreboard bits and their count advance together
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            pending      <= pendingNext;
            pendingCount <= countNext;
        end
    end

    // Read port 1: storage and pending bit, optionally overridden by writeback
    always_comb begin
        rd1 = mem[bus.readAddr1];
        b1  = pending[bus.readAddr1];
        if (bus.readAddr1 == '0) begin
            rd1 = '0;
            b1  = 1'b0;
        end else if (BypassEn && bus.writeEn && bus.writeAddr == bus.readAddr1) begin
            rd1 = bus.writeData;
            b1  = bus.issueEn && bus.issueAddr == bus.readAddr1;
        end
    end

    // Read port 2: same behaviour as port 1
    always_comb begin
        rd2 = mem[bus.readAddr2];
        b2  = pending[bus.readAddr2];
        if (bus.readAddr2 == '0) begin
            rd2 = '0;
            b2  = 1'b0;
        end else if (BypassEn && bus.writeEn && bus.writeAddr == bus.readAddr2) begin
            rd2 = bus.writeData;
            b2  = bus.issueEn && bus.issueAddr == bus.readAddr2;
        end
    end

    assign bus.readData1    = rd1;
    assign bus.readData2    = rd2;
    assign bus.busy1        = b1;
    assign bus.busy2        = b2;
    assign bus.stall        = (bus.readUse1 & b1) | (bus.readUse2 & b2);
    assign bus.pendingCount = pendingCount;
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_register_file;
    localparam int WIDTH       = 32;
    localparam int ADDR_W      = 5;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int RAND_CYCLES = 3000;

`ifdef REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst   = 1'b0;

    register_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] modelMem  [DEPTH];
    bit               modelPend [DEPTH];

    // Reference model: architectural register contents and outstanding writes
    always @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                modelMem[i]  <= '0;
                modelPend[i] <= 1'b0;
            end
        end else begin
            if (bus.writeEn && bus.writeAddr != 0) begin
                modelMem[bus.writeAddr]  <= bus.writeData;
                modelPend[bus.writeAddr] <= 1'b0;
            end
            if (bus.issueEn && bus.issueAddr != 0) begin
                modelPend[bus.issueAddr] <= 1'b1;
            end
        end
    end

    function automatic logic [WIDTH-1:0] expData(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (BypassEn && bus.writeEn && bus.writeAddr == a) return bus.writeData;
        return modelMem[a];
    endfunction

    function automatic logic expBusy(input logic [ADDR_W-1:0] a);
        if (a == 0) return 1'b0;
        if (BypassEn && bus.writeEn && bus.writeAddr == a)
            return bus.issueEn && bus.issueAddr == a;
        return modelPend[a];
    endfunction

    function automatic int expCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(modelPend[i]);
        return n;
    endfunction

    task automatic checkValue(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic eb1;
        logic eb2;
        eb1 = expBusy(bus.readAddr1);
        eb2 = expBusy(bus.readAddr2);
        checkValue({tag, ".readData1"}, bus.readData1, expData(bus.readAddr1));
        checkValue({tag, ".readData2"}, bus.readData2, expData(bus.readAddr2));
        checkValue({tag, ".busy1"}, WIDTH'(bus.busy1), WIDTH'(eb1));
        checkValue({tag, ".busy2"}, WIDTH'(bus.busy2), WIDTH'(eb2));
        checkValue({tag, ".stall"}, WIDTH'(bus.stall),
                   WIDTH'((bus.readUse1 & eb1) | (bus.readUse2 & eb2)));
        checkValue({tag, ".pendingCount"}, WIDTH'(bus.pendingCount), WIDTH'(expCount()));
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                                 input logic u1, input logic u2,
                                 input logic ie, input logic [ADDR_W-1:0] ia,
                                 input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [WIDTH-1:0] wd);
        @(posedge clock);
        #1;
        bus.readAddr1 = ra1;
        bus.readAddr2 = ra2;
        bus.readUse1  = u1;
        bus.readUse2  = u2;
        bus.issueEn   = ie;
        bus.issueAddr = ia;
        bus.writeEn   = we;
        bus.writeAddr = wa;
        bus.writeData = wd;
    endtask

    // Drive one cycle, then check every output mid-cycle against the model
    task automatic cycle(input string tag,
                         input logic [ADDR_W-1:0] ra1, input logic [ADDR_W-1:0] ra2,
                         input logic u1, input logic u2,
                         input logic ie, input logic [ADDR_W-1:0] ia,
                         input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [WIDTH-1:0] wd);
        applyStimulus(ra1, ra2, u1, u2, ie, ia, we, wa, wd);
        @(negedge clock);
        checkOutput(tag);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        bus.readAddr1 = '0;
        bus.readAddr2 = '0;
        bus.readUse1  = 1'b0;
        bus.readUse2  = 1'b0;
        bus.issueEn   = 1'b0;
        bus.issueAddr = '0;
        bus.writeEn   = 1'b0;
        bus.writeAddr = '0;
        bus.writeData = '0;
        #1 rst = 1'b1;
        #2;
        checkValue("reset.readData1", bus.readData1, 32'h0);
        checkValue("reset.busy1", WIDTH'(bus.busy1), 32'h0);
        checkValue("reset.stall", WIDTH'(bus.stall), 32'h0);
        checkValue("reset.pendingCount", WIDTH'(bus.pendingCount), 32'h0);
        checkOutput("reset");

        // Register 0 ignores both writeback and issue
        applyStimulus(0, 0, 1, 1, 1, 0, 1, 0, 32'hDEADBEEF);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("zero");
        cycle("zeroAfter", 0, 0, 1, 1, 0, 0, 0, 0, 0);
        checkValue("zero.readData1", bus.readData1, 32'h0);
        checkValue("zero.busy2", WIDTH'(bus.busy2), 32'h0);
        checkValue("zero.pendingCount", WIDTH'(bus.pendingCount), 32'h0);

        // Issue r3, hold the read, then write it back
        cycle("stallIssue", 3, 0, 1, 0, 1, 3, 0, 0, 0);
        checkValue("stallIssue.stall", WIDTH'(bus.stall), 32'h0);
        cycle("stallWait1", 3, 0, 1, 0, 0, 0, 0, 0, 0);
        checkValue("stallWait1.stall", WIDTH'(bus.stall), 32'h1);
        checkValue("stallWait1.pendingCount", WIDTH'(bus.pendingCount), 32'h1);
        cycle("stallWait2", 3, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle("stallWrite", 3, 0, 1, 0, 0, 0, 1, 3, 32'h1234);
        checkValue("stallWrite.stall", WIDTH'(bus.stall), BypassEn ? 32'h0 : 32'h1);
        checkValue("stallWrite.readData1", bus.readData1, BypassEn ? 32'h1234 : 32'h0);
        cycle("stallDone", 3, 0, 1, 0, 0, 0, 0, 0, 0);
        checkValue("stallDone.stall", WIDTH'(bus.stall), 32'h0);
        checkValue("stallDone.readData1", bus.readData1, 32'h1234);
        checkValue("stallDone.pendingCount", WIDTH'(bus.pendingCount), 32'h0);

        // Pending source that is not used must not stall
        cycle("maskIssue", 0, 7, 1, 0, 1, 7, 0, 0, 0);
        cycle("mask", 0, 7, 1, 0, 0, 0, 0, 0, 0);
        checkValue("mask.busy2", WIDTH'(bus.busy2), 32'h1);
        checkValue("mask.stall", WIDTH'(bus.stall), 32'h0);

        // Issue and writeback to r9 on the same edge: stays pending
        cycle("bothIssue", 9, 7, 1, 0, 1, 9, 0, 0, 0);
        cycle("both", 9, 7, 1, 0, 1, 9, 1, 9, 32'h9999);
        checkValue("both.pendingCount", WIDTH'(bus.pendingCount), 32'h2);
        cycle("bothAfter", 9, 7, 1, 0, 0, 0, 0, 0, 0);
        checkValue("bothAfter.readData1", bus.readData1, 32'h9999);
        checkValue("bothAfter.busy1", WIDTH'(bus.busy1), 32'h1);
        checkValue("bothAfter.pendingCount", WIDTH'(bus.pendingCount), 32'h2);

        // Writeback to a pending r4 while it is being read
        cycle("bypassIssue", 4, 0, 1, 0, 1, 4, 0, 0, 0);
        cycle("bypass", 4, 0, 1, 0, 0, 0, 1, 4, 32'hA5A5A5A5);
        checkValue("bypass.readData1", bus.readData1, BypassEn ? 32'hA5A5A5A5 : 32'h0);
        checkValue("bypass.stall", WIDTH'(bus.stall), BypassEn ? 32'h0 : 32'h1);
        cycle("bypassAfter", 4, 0, 1, 0, 0, 0, 0, 0, 0);
        checkValue("bypassAfter.readData1", bus.readData1, 32'hA5A5A5A5);
        checkValue("bypassAfter.stall", WIDTH'(bus.stall), 32'h0);

        // Mid-run reset with r5 written and pending
        cycle("rstWrite", 5, 0, 1, 0, 0, 0, 1, 5, 32'h55);
        cycle("rstIssue", 5, 0, 1, 0, 1, 5, 0, 0, 0);
        cycle("rstHold", 5, 0, 1, 0, 0, 0, 0, 0, 0);
        checkValue("rstHold.readData1", bus.readData1, 32'h55);
        checkValue("rstHold.pendingCount", WIDTH'(bus.pendingCount), 32'h3);
        #1 rst = 1'b1;
        #1;
        checkValue("midReset.readData1", bus.readData1, 32'h0);
        checkValue("midReset.busy1", WIDTH'(bus.busy1), 32'h0);
        checkValue("midReset.pendingCount", WIDTH'(bus.pendingCount), 32'h0);
        checkOutput("midReset");
        applyStimulus(5, 0, 1, 0, 0, 0, 1, 5, 32'h77);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("postReset");

        // Randomized traffic concentrated on a few registers to force hits
        for (int n = 0; n < RAND_CYCLES; n++) begin
            logic [ADDR_W-1:0] a [4];
            for (int k = 0; k < 4; k++) begin
                a[k] = ($urandom_range(0, 3) != 0) ? ADDR_W'($urandom_range(0, 7))
                                                   : ADDR_W'($urandom_range(0, DEPTH - 1));
            end
            applyStimulus(a[0], a[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 4), a[2],
                          1'($urandom_range(0, 9) < 5), a[3], WIDTH'($urandom));
            rst = 1'b0;
            @(negedge clock);
            checkOutput("random");
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1;
                checkOutput("randomReset");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
